// File: rtl/cc_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cc_cond_unit
// Brief    : Y86-64 Execute-stage condition codes, jXX/cmovXX evaluation and
//            the Memory-stage Cnd pipeline register.
// Revision : 1.0
// ============================================================================
module cc_cond_unit #(
    parameter logic [2:0] CC_RESET   = 3'b100,
    parameter logic [3:0] ICODE_OPQ  = 4'h6,
    parameter logic [3:0] ICODE_JXX  = 4'h7,
    parameter logic [3:0] ICODE_CMOV = 4'h2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_ifun,
    input  logic [2:0] alu_cf,
    input  logic       m_stat_ok,
    input  logic       W_stat_ok,
    input  logic       M_stall,
    input  logic       M_bubble,
    output logic [2:0] cc,
    output logic       e_cnd,
    output logic       M_cnd,
    output logic       set_cc
);

    localparam logic [3:0] c_FN_ALWAYS = 4'd0;
    localparam logic [3:0] c_FN_LE     = 4'd1;
    localparam logic [3:0] c_FN_L      = 4'd2;
    localparam logic [3:0] c_FN_E      = 4'd3;
    localparam logic [3:0] c_FN_NE     = 4'd4;
    localparam logic [3:0] c_FN_GE     = 4'd5;
    localparam logic [3:0] c_FN_G      = 4'd6;

    logic [2:0] r_cc;
    logic       r_m_cnd;
    logic       w_set_cc;
    logic       w_zf;
    logic       w_lt;
    logic       w_eval;
    logic       w_is_cond;

    // A faulting instruction downstream must not leave architectural CC side effects.
    assign w_set_cc = (e_icode == ICODE_OPQ) & m_stat_ok & W_stat_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= alu_cf;
        end
    end

    // Evaluation deliberately uses the stored CC only; there is no bypass from alu_cf.
    assign w_zf = r_cc[2];
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_eval = 1'b0;
        case (e_ifun)
            c_FN_ALWAYS: w_eval = 1'b1;
            c_FN_LE:     w_eval = w_lt | w_zf;
            c_FN_L:      w_eval = w_lt;
            c_FN_E:      w_eval = w_zf;
            c_FN_NE:     w_eval = ~w_zf;
            c_FN_GE:     w_eval = ~w_lt;
            c_FN_G:      w_eval = ~w_lt & ~w_zf;
            default:     w_eval = 1'b0;
        endcase
    end

    assign w_is_cond = (e_icode == ICODE_JXX) | (e_icode == ICODE_CMOV);

    // Bubble takes priority over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_cnd <= 1'b0;
        end else if (M_bubble) begin
            r_m_cnd <= 1'b0;
        end else if (!M_stall) begin
            r_m_cnd <= w_is_cond & w_eval;
        end
    end

    assign cc     = r_cc;
    assign e_cnd  = w_is_cond & w_eval;
    assign M_cnd  = r_m_cnd;
    assign set_cc = w_set_cc;

endmodule
`default_nettype wire

// File: tb/tb_cc_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_cond_unit
// Brief    : Self-checking bench for cc_cond_unit with an abstract reference model.
// Revision : 1.0
// ============================================================================
module tb_cc_cond_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] e_icode;
    logic [3:0] e_ifun;
    logic [2:0] alu_cf;
    logic       m_stat_ok;
    logic       W_stat_ok;
    logic       M_stall;
    logic       M_bubble;
    logic [2:0] cc;
    logic       e_cnd;
    logic       M_cnd;
    logic       set_cc;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // Reference model state
    logic [2:0] mdl_cc;
    logic       mdl_mcnd;

    cc_cond_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e_icode   (e_icode),
        .e_ifun    (e_ifun),
        .alu_cf    (alu_cf),
        .m_stat_ok (m_stat_ok),
        .W_stat_ok (W_stat_ok),
        .M_stall   (M_stall),
        .M_bubble  (M_bubble),
        .cc        (cc),
        .e_cnd     (e_cnd),
        .M_cnd     (M_cnd),
        .set_cc    (set_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_holds(input logic [2:0] flags, input logic [3:0] fn);
        bit zf, sf, of, less;
        zf   = flags[2];
        sf   = flags[1];
        of   = flags[0];
        less = (sf != of);
        if (fn == 0) return 1;
        if (fn == 1) return less || zf;
        if (fn == 2) return less;
        if (fn == 3) return zf;
        if (fn == 4) return !zf;
        if (fn == 5) return !less;
        if (fn == 6) return !less && !zf;
        return 0;
    endfunction

    function automatic bit mdl_e_cnd(input logic [2:0] flags, input logic [3:0] ic, input logic [3:0] fn);
        if (ic == 4'h7 || ic == 4'h2) return cond_holds(flags, fn);
        return 0;
    endfunction

    function automatic bit mdl_set_cc();
        return (e_icode == 4'h6) && m_stat_ok && W_stat_ok;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cc   = 3'b100;
            mdl_mcnd = 1'b0;
        end else begin
            bit nxt;
            nxt = mdl_e_cnd(mdl_cc, e_icode, e_ifun);
            if (M_bubble)      mdl_mcnd = 1'b0;
            else if (!M_stall) mdl_mcnd = nxt;
            if (mdl_set_cc()) mdl_cc = alu_cf;
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_cc",     cc,               mdl_cc);
            chk("cmp_M_cnd",  {2'b0, M_cnd},    {2'b0, mdl_mcnd});
            chk("cmp_e_cnd",  {2'b0, e_cnd},    {2'b0, mdl_e_cnd(mdl_cc, e_icode, e_ifun)});
            chk("cmp_set_cc", {2'b0, set_cc},   {2'b0, mdl_set_cc()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cf,
                         input logic mok, input logic wok, input logic st, input logic bb);
        e_icode   = ic;
        e_ifun    = fn;
        alu_cf    = cf;
        m_stat_ok = mok;
        W_stat_ok = wok;
        M_stall   = st;
        M_bubble  = bb;
    endtask

    task automatic load_cc(input logic [2:0] v);
        drive(4'h6, 4'h0, v, 1, 1, 0, 0);
        tick();
    endtask

    initial begin
        logic [2:0] sweep [6];
        sweep[0] = 3'b000; sweep[1] = 3'b001; sweep[2] = 3'b010;
        sweep[3] = 3'b011; sweep[4] = 3'b100; sweep[5] = 3'b110;

        rst_n = 1'b1;
        drive(4'h1, 4'h0, 3'b000, 1, 1, 0, 0);
        #1 rst_n = 1'b0;
        #12 rst_n = 1'b1;
        tick();
        cmp_en = 1;

        // Dirty the state, then assert reset mid-cycle
        load_cc(3'b011);
        drive(4'h7, 4'h0, 3'b000, 1, 1, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_cc",   cc,            3'b100);
        chk("rst_Mcnd", {2'b0, M_cnd}, 3'b000);
        drive(4'h7, 4'h3, 3'b000, 1, 1, 0, 0);
        #1;
        chk("rst_e_cnd_je", {2'b0, e_cnd}, 3'b001);
        tick();
        rst_n = 1'b1;
        tick();

        // CC update and evaluation against new flags
        drive(4'h6, 4'h0, 3'b011, 1, 1, 0, 0);
        #1 chk("opq_set_cc", {2'b0, set_cc}, 3'b001);
        tick();
        chk("opq_cc", cc, 3'b011);
        drive(4'h7, 4'h2, 3'b000, 1, 1, 0, 0); #1 chk("jl_011",  {2'b0, e_cnd}, 3'b000);
        drive(4'h7, 4'h5, 3'b000, 1, 1, 0, 0); #1 chk("jge_011", {2'b0, e_cnd}, 3'b001);
        drive(4'h7, 4'h1, 3'b000, 1, 1, 0, 0); #1 chk("jle_011", {2'b0, e_cnd}, 3'b000);
        tick();

        // Exception suppression
        load_cc(3'b100);
        drive(4'h6, 4'h0, 3'b010, 0, 1, 0, 0);
        #1 chk("sup_m_set_cc", {2'b0, set_cc}, 3'b000);
        tick();
        chk("sup_m_cc", cc, 3'b100);
        drive(4'h6, 4'h0, 3'b010, 1, 0, 0, 0);
        #1 chk("sup_w_set_cc", {2'b0, set_cc}, 3'b000);
        tick();
        chk("sup_w_cc", cc, 3'b100);

        // Condition sweep with cmovXX, and a non-conditional icode
        for (int s = 0; s < 6; s++) begin
            load_cc(sweep[s]);
            for (int f = 0; f < 8; f++) begin
                drive(4'h2, 4'(f), 3'b000, 1, 1, 0, 0);
                #1 chk("sweep_cmov", {2'b0, e_cnd}, {2'b0, cond_holds(sweep[s], 4'(f))});
            end
            drive(4'h3, 4'h0, 3'b000, 1, 1, 0, 0);
            #1 chk("sweep_irmov", {2'b0, e_cnd}, 3'b000);
            tick();
        end
        load_cc(3'b010);
        drive(4'h2, 4'h1, 3'b000, 1, 1, 0, 0); #1 chk("lit010_le", {2'b0, e_cnd}, 3'b001);
        drive(4'h2, 4'h3, 3'b000, 1, 1, 0, 0); #1 chk("lit010_e",  {2'b0, e_cnd}, 3'b000);
        drive(4'h2, 4'h4, 3'b000, 1, 1, 0, 0); #1 chk("lit010_ne", {2'b0, e_cnd}, 3'b001);
        drive(4'h2, 4'h6, 3'b000, 1, 1, 0, 0); #1 chk("lit010_g",  {2'b0, e_cnd}, 3'b000);
        drive(4'h2, 4'h7, 3'b000, 1, 1, 0, 0); #1 chk("lit010_f7", {2'b0, e_cnd}, 3'b000);
        tick();

        // M register: load, stall, bubble-over-stall
        drive(4'h7, 4'h0, 3'b000, 1, 1, 0, 0);
        tick();
        chk("m_load", {2'b0, M_cnd}, 3'b001);
        drive(4'h3, 4'h0, 3'b000, 1, 1, 1, 0);
        tick();
        chk("m_stall", {2'b0, M_cnd}, 3'b001);
        drive(4'h7, 4'h0, 3'b000, 1, 1, 1, 1);
        tick();
        chk("m_bubble", {2'b0, M_cnd}, 3'b000);

        // Back-to-back OPq then je
        load_cc(3'b000);
        drive(4'h6, 4'h0, 3'b100, 1, 1, 0, 0);
        tick();
        drive(4'h7, 4'h3, 3'b000, 1, 1, 0, 0);
        #1;
        chk("b2b_cc",    cc,            3'b100);
        chk("b2b_e_cnd", {2'b0, e_cnd}, 3'b001);
        tick();
        chk("b2b_M_cnd", {2'b0, M_cnd}, 3'b001);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ic;
            case ($urandom_range(0, 4))
                0: ic = 4'h6;
                1: ic = 4'h7;
                2: ic = 4'h2;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            drive(ic, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: simulation did not complete, limit reached at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
- Consumer end of the ALU condition-flag interface in the Execute stage of the Y86-64 pipeline.
- Latches the ALU's 3-bit condition flags into the architectural condition-code (CC) register when an OPq instruction executes.
- Evaluates the jXX/cmovXX condition against the stored CC.
- Carries the resulting Cnd into the Memory-stage pipeline register, with stall and bubble control.

Parameters:
- CC_RESET, 3'b100, CC value after reset ({ZF,SF,OF}: ZF=1, SF=0, OF=0).
- ICODE_OPQ, 4'h6, icode that updates CC.
- ICODE_JXX, 4'h7, icode for conditional jumps.
- ICODE_CMOV, 4'h2, icode for rrmovq/cmovXX.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- e_icode  input  4  icode of the instruction in Execute.
- e_ifun  input  4  ifun of the instruction in Execute.
- alu_cf  input  3  ALU flags: alu_cf[2]=ZF, alu_cf[1]=SF, alu_cf[0]=OF.
- m_stat_ok  input  1  1 = Memory-stage instruction has no exception.
- W_stat_ok  input  1  1 = Writeback-stage instruction has no exception.
- M_stall  input  1  hold the M-stage Cnd register.
- M_bubble  input  1  load NOP state into the M-stage Cnd register.
- cc  output  3  current CC register, same bit order as alu_cf.
- e_cnd  output  1  combinational condition result for the Execute instruction.
- M_cnd  output  1  registered Cnd presented to the Memory stage.
- set_cc  output  1  combinational: CC will update at the next edge.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-operation):
  - cc=CC_RESET.
  - M_cnd=0.
  - Combinational outputs follow the reset state.
- Release of reset is synchronous to the next clk edge.
- set_cc = (e_icode==ICODE_OPQ) & m_stat_ok & W_stat_ok.
- CC register:
  - On rising clk with set_cc=1: cc <= alu_cf.
  - Otherwise cc holds.
  - No stall input; suppression comes only via the stat terms.
  - Latency: flags from the OPq in E are visible on cc one cycle later, so the next instruction entering E sees them. There is no same-cycle bypass.
- Condition evaluation (combinational on the registered cc, never on alu_cf), let lt = SF^OF:
  - ifun 0: 1 (always).
  - ifun 1 (le): lt|ZF.
  - ifun 2 (l): lt.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~lt.
  - ifun 6 (g): ~lt & ~ZF.
  - ifun 7–15: 0.
- e_cnd = eval(e_ifun) when e_icode is ICODE_JXX or ICODE_CMOV; otherwise e_cnd = 0.
- M_cnd register, priority order on rising clk:
  1. M_bubble=1 → M_cnd <= 0 (bubble wins over stall).
  2. M_stall=1 → hold.
  3. Otherwise M_cnd <= e_cnd.
- Simultaneous events:
  - An OPq in E with an exception in M or W leaves cc unchanged.
  - A jXX in E evaluates the old cc while an OPq in E updates cc in the same cycle. The two cannot coexist because only one instruction is in E per cycle; the unit is designed for that case.
- X handling: every register has a defined reset; no latches.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → cc=3'b100 and M_cnd=0 immediately. For e_icode=7, e_ifun=3 → e_cnd=1 (ZF=1).
2. CC update: e_icode=6, alu_cf=3'b011, both stat_ok=1, one edge → cc=3'b011. Then e_icode=7:
   - ifun=2 → e_cnd=0 (lt=0).
   - ifun=5 → e_cnd=1.
   - ifun=1 → e_cnd=0.
3. Exception suppression: cc=3'b100, e_icode=6, alu_cf=3'b010, m_stat_ok=0 → set_cc=0 and cc stays 3'b100. Repeat with W_stat_ok=0 → same result.
4. Full condition sweep: for each cc in {000,001,010,011,100,110}, e_icode=2, ifun 0..7 → e_cnd matches the table (e.g. cc=3'b010: le=1, l=1, e=0, ne=1, ge=0, g=0, ifun7=0). With e_icode=3, any ifun → e_cnd=0.
5. M register: e_cnd=1 with no control, edge → M_cnd=1. Then M_stall=1 with e_cnd=0 → M_cnd stays 1. Then M_bubble=1 and M_stall=1 → M_cnd=0.
6. Back-to-back: an OPq (alu_cf=100) followed by jXX ifun=3 on consecutive cycles → the jump sees cc=100 and e_cnd=1. M_cnd=1 one cycle after the jump was in E.
